wb_select_unit: RTL
===================

# wb_select_unit

Parametrised write-back select unit for the multicycle MIPS datapath. It generalises the register-file write-data selector from a fixed eight-way combinational mux into an N-source, WIDTH-bit selector with a request/commit handshake. It waits for slow sources (HI/LO from mult/div, load unit) to signal valid, then issues a single registered register-file write. It sits between the execution/memory units and the register file write port, driven by the control unit.

## Interface
- WIDTH, 32, data width of every source and of wb_data
- N_SRC, 8, number of write-back sources (≥2)
- SEL_W, $clog2(N_SRC), select field width
- REG_ADDR_W, 5, register-file address width
- TIMEOUT, 64, max WAIT cycles before abort (used only with WB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  control unit requests a write-back
- req_ready  out  1  unit can accept a request (state IDLE)
- req_sel  in  SEL_W  source index to write back
- req_dest  in  REG_ADDR_W  destination register
- src_data  in  N_SRC*WIDTH  packed sources, source i at [i*WIDTH +: WIDTH]
- src_valid  in  N_SRC  per-source data-valid
- flush  in  1  abort pending request
- wb_en  out  1  register-file write enable, one-cycle pulse
- wb_addr  out  REG_ADDR_W  write address
- wb_data  out  WIDTH  write data
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky timeout flag

## Operation
- States: IDLE, WAIT, COMMIT.
- IDLE: req_ready=1. On req_valid=1 with flush=0, latch sel_q=req_sel, dest_q=req_dest. If src_valid[req_sel]=1 in the same cycle, capture src_data slice into data_q and go to COMMIT. Otherwise go to WAIT.
- WAIT: each cycle, if src_valid[sel_q]=1, capture the slice and go to COMMIT. Later changes to the source do not affect data_q.
- COMMIT: wb_en=1 for exactly this cycle, wb_addr=dest_q, wb_data=data_q. Go to IDLE; new requests are accepted only from the next cycle.
- dest_q==0 ($zero): full sequence runs but wb_en stays 0 in COMMIT; wb_addr/wb_data still updated.
- sel ≥ N_SRC (non-power-of-2 N_SRC): treated as always valid with data 0.
- flush=1 in IDLE or WAIT: next state IDLE, no write, request dropped; req_valid ignored that cycle.
- flush=1 in COMMIT: no effect; the write completes.
- wb_addr/wb_data hold their last committed values outside COMMIT.

## Timing
- reset=0 at a clock edge: state IDLE, wb_en=0, wb_addr=0, wb_data=0, busy=0, timeout_err=0, internal counter 0. req_ready=1 from the first cycle after reset. Reset mid-request drops the request silently.
- Latency: request accepted at edge k with source valid gives wb_en high in the cycle after edge k (1 cycle).
- Source valid m cycles after acceptance gives wb_en in cycle k+m+1.
- Minimum back-to-back spacing: one request every 2 cycles (IDLE→COMMIT→IDLE).
- req_ready, busy and wb_en are decoded from the registered state; there are no combinational paths from inputs to outputs.

## Configuration
- WB_TIMEOUT_EN defined:
  - Counter runs in WAIT and clears on entering WAIT.
  - On reaching TIMEOUT cycles with no valid: set timeout_err (sticky until reset) and return to IDLE with no write.
  - If valid arrives on the same cycle the count hits TIMEOUT, valid wins and the write commits.
- WB_TIMEOUT_EN undefined: WAIT is unbounded, timeout_err is tied 0, and no counter logic is present.

## Structure
- Package wb_select_pkg: state enum typedef (IDLE/WAIT/COMMIT), default WIDTH/REG_ADDR_W constants, and source-index localparams for the datapath (ALU_OUT=0, MDR=1, HI=2, LO=3, SHIFT=4, LOAD=5, SLT=6, CONST_227=7).
- Sub-module wb_src_mux: combinational N_SRC-to-1 indexed mux producing the data slice and valid bit, with the out-of-range rule applied. The top level holds the FSM, capture registers and counter.

## Test plan
- Reset then idle: reset=0 for 2 cycles → all outputs 0, req_ready=1 after release, no wb_en for 10 idle cycles.
- Immediate source: req_sel=0, req_dest=8, src0=0xDEADBEEF valid → wb_en pulse next cycle, wb_addr=8, wb_data=0xDEADBEEF; busy high exactly 1 cycle.
- Delayed HI: req_sel=2, dest=9, src_valid[2] asserted 5 cycles later with 0x12345678 → wb_en in the cycle after valid, data 0x12345678; src2 changed afterwards → wb_data unchanged.
- $zero and flush:
  - dest=0, sel=0 → COMMIT occurs, wb_en stays 0.
  - Request sel=3 waiting, flush on cycle 3 → IDLE, no wb_en, next request accepted normally.
- Timeout (WB_TIMEOUT_EN, TIMEOUT=4): sel=5 never valid → after 4 WAIT cycles timeout_err=1, no wb_en, state IDLE; flag persists until reset.

Source files
------------

// File: rtl/wb_select_pkg.sv
// Shared types and constants for the write-back select unit.
// The optional WAIT timeout lives in wb_select_unit behind WB_TIMEOUT_EN.
package wb_select_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2
  } wbState_t;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;

  // Source indices as wired by the multicycle datapath
  localparam int ALU_OUT   = 0;
  localparam int MDR       = 1;
  localparam int HI        = 2;
  localparam int LO        = 3;
  localparam int SHIFT     = 4;
  localparam int LOAD      = 5;
  localparam int SLT       = 6;
  localparam int CONST_227 = 7;

endpackage

// File: rtl/wb_src_mux.sv
// N_SRC-to-1 indexed source mux returning the selected data slice and its valid bit.
// An index past the last source reads as always-valid zero data.
module wb_src_mux #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 8,
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_SRC*WIDTH-1:0] srcData,
  input  logic [N_SRC-1:0]       srcValid,
  output logic [WIDTH-1:0]       data,
  output logic                   valid
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred;
    // they also encode the out-of-range rule (valid, zero data).
    data  = '0;
    valid = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      if (int'(sel) == i) begin
        data  = srcData[i*WIDTH +: WIDTH];
        valid = srcValid[i];
      end
    end
  end

endmodule

// File: rtl/wb_select_unit.sv
// Write-back select unit: accepts a request, waits for the chosen source, issues one write.
// Define WB_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles with a sticky timeout_err.
module wb_select_unit
  import wb_select_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int N_SRC      = 8,
  parameter int SEL_W      = $clog2(N_SRC),
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SEL_W-1:0]       req_sel,
  input  logic [REG_ADDR_W-1:0]  req_dest,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic                   flush,
  output logic                   wb_en,
  output logic [REG_ADDR_W-1:0]  wb_addr,
  output logic [WIDTH-1:0]       wb_data,
  output logic                   busy,
  output logic                   timeout_err
);

  if (N_SRC < 2 || TIMEOUT < 1) begin : gBadParams
    $error("wb_select_unit: N_SRC must be >= 2 and TIMEOUT >= 1");
  end

  wbState_t              stateQ, stateD;
  logic [SEL_W-1:0]      selQ, muxSel;
  logic [REG_ADDR_W-1:0] destQ, wbAddrQ;
  logic [WIDTH-1:0]      dataQ, muxData;
  logic                  muxValid, accept, capture, timeoutHit;

  // In IDLE the incoming request is probed directly so a ready source commits next cycle
  assign muxSel  = (stateQ == IDLE) ? req_sel : selQ;
  assign accept  = (stateQ == IDLE) && req_valid && !flush;
  assign capture = (stateD == COMMIT);

  wb_src_mux #(
    .WIDTH(WIDTH),
    .N_SRC(N_SRC),
    .SEL_W(SEL_W)
  ) uSrcMux (
    .sel     (muxSel),
    .srcData (src_data),
    .srcValid(src_valid),
    .data    (muxData),
    .valid   (muxValid)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (accept) stateD = muxValid ? COMMIT : WAIT;
      WAIT: begin
        if (flush)           stateD = IDLE;
        else if (muxValid)   stateD = COMMIT;
        else if (timeoutHit) stateD = IDLE;
      end
      COMMIT:  stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (stateQ == IDLE);
    busy      = (stateQ != IDLE);
    wb_en     = (stateQ == COMMIT) && (wbAddrQ != '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: the capture registers are reset because they drive wb_addr/wb_data,
    // which must read zero after reset.
    if (!reset) begin
      selQ    <= '0;
      destQ   <= '0;
      dataQ   <= '0;
      wbAddrQ <= '0;
    end else begin
      if (accept) begin
        selQ  <= req_sel;
        destQ <= req_dest;
      end
      if (capture) begin
        dataQ   <= muxData;
        wbAddrQ <= (stateQ == IDLE) ? req_dest : destQ;
      end
    end
  end

  assign wb_addr = wbAddrQ;
  assign wb_data = dataQ;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cntQ;
  logic             errQ;

  // Fires on the TIMEOUT-th WAIT cycle; a valid source on that same cycle still commits
  assign timeoutHit = (stateQ == WAIT) && (cntQ == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cntQ <= '0;
      errQ <= 1'b0;
    end else begin
      cntQ <= (stateQ == WAIT) ? cntQ + 1'b1 : '0;
      if (timeoutHit && !flush && !muxValid) errQ <= 1'b1;
    end
  end

  assign timeout_err = errQ;
`else
  assign timeoutHit  = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
